// File: rtl/input_conditioner_if.sv
// Purpose: groups raw button/switch inputs and conditioned outputs of input_conditioner.
// Latency: n/a (signal bundle only).
// Backpressure: none; all signals are free-running levels or single-cycle pulses.
interface input_conditioner_if;
  logic       Run_n;
  logic       ClearA_LoadB_n;
  logic [7:0] S_raw;
  logic       Run_held;
  logic       ClearA_LoadB_held;
  logic       Run_pulse;
  logic       ClearA_LoadB_pulse;
  logic [7:0] S_sync;

  // Board/bench side: drives raw inputs, observes conditioned outputs.
  modport master (
    output Run_n, ClearA_LoadB_n, S_raw,
    input  Run_held, ClearA_LoadB_held, Run_pulse, ClearA_LoadB_pulse, S_sync
  );

  // Conditioner side.
  modport slave (
    input  Run_n, ClearA_LoadB_n, S_raw,
    output Run_held, ClearA_LoadB_held, Run_pulse, ClearA_LoadB_pulse, S_sync
  );
endinterface

// File: rtl/input_conditioner.sv
// Purpose: sync + debounce two active-low buttons into level/press-pulse; 2-FF sync of 8 switches.
// Latency: held D+2 edges, pulse D+3 edges, switches 2 edges (D = DEBOUNCE_CYCLES).
// Backpressure: none; outputs are free-running registered levels and one-cycle pulses.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input logic                Clk,
  input logic                Reset,
  input_conditioner_if.slave bus
);

  // Counter terminal value: the D-th consecutive mismatching sample commits the change.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel 0 = Run, channel 1 = ClearA_LoadB. Inverted so 1 = pressed.
  logic [1:0] btn_pressed;
  assign btn_pressed = ~{bus.ClearA_LoadB_n, bus.Run_n};

  logic [1:0]            sync1_q;
  logic [1:0]            sync2_q;
  logic [1:0]            stable_q, stable_d;
  logic [1:0]            stable_dly_q;
  logic [1:0]            pulse_q, pulse_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]            s_sync1_q;
  logic [7:0]            s_sync2_q;

  // Debounce next state: any sample agreeing with the accepted level restarts the count,
  // so only an unbroken run of D disagreeing samples moves the stable level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = '0;
    for (int c = 0; c < 2; c++) begin
      if (sync2_q[c] != stable_q[c]) begin
        if (cnt_q[c] == CNT_MAX) begin
          stable_d[c] = sync2_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
      // Rising edge of the accepted level only; release and long holds give nothing.
      pulse_d[c] = stable_q[c] & ~stable_dly_q[c];
    end
  end

  // Button synchronizers, debounce state and pulse registers; reset means "released".
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      pulse_q      <= '0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_pressed;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      pulse_q      <= pulse_d;
      cnt_q        <= cnt_d;
    end
  end

  // Switch synchronizer: two flops per bit, no filtering.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s_sync1_q <= '0;
      s_sync2_q <= '0;
    end else begin
      s_sync1_q <= bus.S_raw;
      s_sync2_q <= s_sync1_q;
    end
  end

  assign bus.Run_held           = stable_q[0];
  assign bus.ClearA_LoadB_held  = stable_q[1];
  assign bus.Run_pulse          = pulse_q[0];
  assign bus.ClearA_LoadB_pulse = pulse_q[1];
  assign bus.S_sync             = s_sync2_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Purpose: directed self-checking bench for input_conditioner with DEBOUNCE_CYCLES = 4.
// Latency: expected edge positions are hand-derived from the press/release timing.
// Backpressure: none; fixed-length stimulus loops only.
module tb_input_conditioner;

  logic Clk;
  logic Reset;
  int   n_vec;
  int   n_bad;
  int   n_pulse;

  input_conditioner_if bus ();

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample and drive 1 time unit after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    Reset              = 1'b0;
    bus.Run_n          = 1'b1;
    bus.ClearA_LoadB_n = 1'b1;
    bus.S_raw          = 8'h00;
    tick();
    tick();
    check_vec("rst_run_held", {7'd0, bus.Run_held}, 8'd0);
    check_vec("rst_cl_held", {7'd0, bus.ClearA_LoadB_held}, 8'd0);
    check_vec("rst_run_pulse", {7'd0, bus.Run_pulse}, 8'd0);
    check_vec("rst_cl_pulse", {7'd0, bus.ClearA_LoadB_pulse}, 8'd0);
    check_vec("rst_s_sync", bus.S_sync, 8'h00);
    Reset = 1'b1;
    tick();
    tick();

    // Press Run; next edge is k. After edge k+i: held = (i>=5), pulse = (i==6).
    bus.Run_n = 1'b0;
    n_pulse = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_vec($sformatf("press_held_k%0d", i), {7'd0, bus.Run_held}, {7'd0, i >= 5});
      check_vec($sformatf("press_pulse_k%0d", i), {7'd0, bus.Run_pulse}, {7'd0, i == 6});
      if (bus.Run_pulse) n_pulse++;
    end
    check_vec("press_pulse_count", 8'(n_pulse), 8'd1);

    // Release; release sampled at edge r. Held falls after r+5, no pulse.
    bus.Run_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_vec($sformatf("rel_held_r%0d", i), {7'd0, bus.Run_held}, {7'd0, i < 5});
      check_vec($sformatf("rel_pulse_r%0d", i), {7'd0, bus.Run_pulse}, 8'd0);
    end

    // Glitches of 3 samples are rejected.
    for (int rep = 0; rep < 5; rep++) begin
      bus.Run_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        check_vec("glitch_held", {7'd0, bus.Run_held}, 8'd0);
        check_vec("glitch_pulse", {7'd0, bus.Run_pulse}, 8'd0);
      end
      bus.Run_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        check_vec("glitch_held", {7'd0, bus.Run_held}, 8'd0);
        check_vec("glitch_pulse", {7'd0, bus.Run_pulse}, 8'd0);
      end
    end

    // Both buttons pressed at the same edge.
    bus.Run_n          = 1'b0;
    bus.ClearA_LoadB_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_vec($sformatf("both_held_k%0d", i),
                {6'd0, bus.ClearA_LoadB_held, bus.Run_held}, (i >= 5) ? 8'd3 : 8'd0);
      check_vec($sformatf("both_pulse_k%0d", i),
                {6'd0, bus.ClearA_LoadB_pulse, bus.Run_pulse}, (i == 6) ? 8'd3 : 8'd0);
    end
    bus.Run_n          = 1'b1;
    bus.ClearA_LoadB_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check_vec("both_released", {6'd0, bus.ClearA_LoadB_held, bus.Run_held}, 8'd0);

    // Run held and switches set, then ClearA_LoadB counts 3 samples before reset hits.
    bus.S_raw = 8'hA5;
    bus.Run_n = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_vec("pre_rst_run_held", {7'd0, bus.Run_held}, 8'd1);
    check_vec("pre_rst_s_sync", bus.S_sync, 8'hA5);
    bus.ClearA_LoadB_n = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_vec("pre_rst_cl_held", {7'd0, bus.ClearA_LoadB_held}, 8'd0);
    Reset = 1'b0;
    #1;
    check_vec("async_rst_run_held", {7'd0, bus.Run_held}, 8'd0);
    check_vec("async_rst_cl_held", {7'd0, bus.ClearA_LoadB_held}, 8'd0);
    check_vec("async_rst_pulses", {6'd0, bus.ClearA_LoadB_pulse, bus.Run_pulse}, 8'd0);
    check_vec("async_rst_s_sync", bus.S_sync, 8'h00);
    tick();
    tick();
    Reset = 1'b1;
    // First post-reset edge is j; the one pulse lands after edge j+6.
    n_pulse = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_vec($sformatf("post_rst_cl_pulse_j%0d", i),
                {7'd0, bus.ClearA_LoadB_pulse}, {7'd0, i == 6});
      check_vec($sformatf("post_rst_cl_held_j%0d", i),
                {7'd0, bus.ClearA_LoadB_held}, {7'd0, i >= 5});
      if (bus.ClearA_LoadB_pulse) n_pulse++;
    end
    check_vec("post_rst_cl_pulse_count", 8'(n_pulse), 8'd1);
    bus.Run_n          = 1'b1;
    bus.ClearA_LoadB_n = 1'b1;

    // Switch synchronizer: exactly two edges, old value until then.
    bus.S_raw = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    check_vec("s_sync_zero", bus.S_sync, 8'h00);
    bus.S_raw = 8'h5A;
    tick();
    check_vec("s_sync_edge1", bus.S_sync, 8'h00);
    tick();
    check_vec("s_sync_edge2", bus.S_sync, 8'h5A);
    tick();
    check_vec("s_sync_edge3", bus.S_sync, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
